// File: rtl/wimax_qpsk_mapper.sv
// Serial-bit to Gray-coded QPSK mapper for 802.16 interleaved blocks, with a symbol FIFO on a valid/ready output.
// Optional status ports (overflow, fifo_level) are enabled by defining WIMAX_QPSK_OVF_STATUS_EN.
module wimax_qpsk_mapper #(
  parameter int DATA_W     = 16,
  parameter int AMP        = 23170,
  parameter int BLOCK_BITS = 192,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic signed [DATA_W-1:0] i_out,
  output logic signed [DATA_W-1:0] q_out,
  output logic                     last_out,
  output logic                     valid_out,
  input  logic                     ready_in
`ifdef WIMAX_QPSK_OVF_STATUS_EN
  ,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`endif
);

  localparam int SYMS  = BLOCK_BITS / 2;
  localparam int SC_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  localparam logic [SC_W-1:0]         LAST_IDX = SC_W'(SYMS - 1);
  localparam logic [LVL_W-1:0]        FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic signed [DATA_W-1:0] AMP_POS = DATA_W'(AMP);
  localparam logic signed [DATA_W-1:0] AMP_NEG = -AMP_POS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_Q
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
    logic                     last;
  } sym_t;

  state_t           state;
  logic             i_bit;
  logic [SC_W-1:0]  sym_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  sym_t             mem [FIFO_DEPTH];

  logic pair_done;
  logic full;
  logic empty;
  logic push;
  logic pop;
  sym_t new_sym;
  sym_t head;

  assign pair_done = (state == WAIT_Q) && valid_in;
  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign pop       = !empty && ready_in;
  // A full FIFO still accepts a symbol when the head leaves in the same cycle.
  assign push      = pair_done && (!full || pop);

  always_comb begin
    new_sym      = '0;
    new_sym.i    = i_bit   ? AMP_NEG : AMP_POS;
    new_sym.q    = data_in ? AMP_NEG : AMP_POS;
    new_sym.last = (sym_cnt == LAST_IDX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i_bit   <= 1'b0;
      sym_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      case (state)
        IDLE:   state <= WAIT_I;
        WAIT_I: begin
          if (valid_in) begin
            i_bit <= data_in;
            state <= WAIT_Q;
          end
        end
        WAIT_Q: begin
          if (valid_in) begin
            state <= WAIT_I;
          end
        end
        default: state <= IDLE;
      endcase

      // Dropped pairs still advance the counter so block alignment survives an overflow.
      if (pair_done) begin
        sym_cnt <= (sym_cnt == LAST_IDX) ? '0 : sym_cnt + SC_W'(1);
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; contents are only visible through valid_out, which the level controls.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_sym;
  end

  assign head      = empty ? '0 : mem[rd_ptr];
  assign valid_out = !empty;
  assign i_out     = head.i;
  assign q_out     = head.q;
  assign last_out  = head.last;
  assign ready_out = (state != IDLE) && !full;

`ifdef WIMAX_QPSK_OVF_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (pair_done && !push) begin
      overflow <= 1'b1;
    end
  end

  assign fifo_level = level;
`else
  // Without the status ports a dropped symbol leaves no trace beyond the advanced counter.
`endif

endmodule

// File: tb/tb_wimax_qpsk_mapper.sv
// Directed bench for wimax_qpsk_mapper: scoreboard of expected symbols, compared by a monitor on every output transfer.
// Status-port checks are active when WIMAX_QPSK_OVF_STATUS_EN is defined.
module tb_wimax_qpsk_mapper;

  localparam int DATA_W     = 16;
  localparam int BLOCK_BITS = 192;
  localparam int FIFO_DEPTH = 4;
  localparam int SYMS       = BLOCK_BITS / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic        last_out;
  logic        valid_out;
  logic        ready_in;
`ifdef WIMAX_QPSK_OVF_STATUS_EN
  logic        overflow;
  logic [2:0]  fifo_level;
`endif

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   sym_idx    = 0;

  wimax_qpsk_mapper #(
    .DATA_W    (DATA_W),
    .AMP       (23170),
    .BLOCK_BITS(BLOCK_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .i_out    (i_out),
    .q_out    (q_out),
    .last_out (last_out),
    .valid_out(valid_out),
    .ready_in (ready_in)
`ifdef WIMAX_QPSK_OVF_STATUS_EN
    ,
    .overflow  (overflow),
    .fifo_level(fifo_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] map_bit(input logic b);
    return b ? 16'hA57E : 16'h5A82;
  endfunction

  // Scoreboard model: every pair advances the block counter; only kept pairs are expected at the output.
  task automatic pair_model(input logic a, input logic b, input logic keep);
    exp_t e;
    e.i    = map_bit(a);
    e.q    = map_bit(b);
    e.last = (sym_idx == SYMS - 1);
    if (keep) sb.push_back(e);
    sym_idx = (sym_idx + 1) % SYMS;
  endtask

  task automatic send_pair(input logic a, input logic b, input logic keep, input logic check_lat);
    valid_in = 1'b1;
    data_in  = a;
    @(posedge clk); #1;
    data_in = b;
    pair_model(a, b, keep);
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (check_lat) begin
      @(negedge clk);
      check("latency_valid_out", 32'(valid_out), 32'd1);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    ready_in = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    reset    = 1'b1;
    sb.delete();
    sym_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_ready_out", 32'(ready_out), 32'd0);
    check("rst_iq_out", {i_out, q_out}, 32'd0);
    check("rst_last_out", 32'(last_out), 32'd0);
`ifdef WIMAX_QPSK_OVF_STATUS_EN
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready_out", 32'(ready_out), 32'd0);
    @(posedge clk); #1;
    check("run_ready_out", 32'(ready_out), 32'd1);
  endtask

  // Monitor: every handshake pops one expected symbol; an empty FIFO must present zeros.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (valid_out && ready_in) begin
          check("symbol_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("i_out", 32'(i_out), 32'(e.i));
            check("q_out", 32'(q_out), 32'(e.q));
            check("last_out", 32'(last_out), 32'(e.last));
          end
        end else if (valid_out === 1'b0) begin
          check("empty_iq_zero", {i_out, q_out}, 32'd0);
          check("empty_last_zero", 32'(last_out), 32'd0);
        end
      end
    end
  end

  initial begin
    logic a, b;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;
    ready_in = 1'b0;

    // Basic mapping of all four bit pairs with one-cycle latency.
    do_reset();
    ready_in = 1'b1;
    send_pair(1'b0, 1'b0, 1'b1, 1'b1);
    send_pair(1'b0, 1'b1, 1'b1, 1'b1);
    send_pair(1'b1, 1'b0, 1'b1, 1'b1);
    send_pair(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    drain();

    // Two full blocks of continuous random bits: last on symbols 95 and 191.
    do_reset();
    ready_in = 1'b1;
    for (int p = 0; p < 2 * SYMS; p++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      send_pair(a, b, 1'b1, 1'b0);
    end
    drain();

    // Gaps between the I and Q bits; junk data while valid_in is low.
    valid_in = 1'b1;
    data_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    valid_in = 1'b1;
    data_in  = 1'b0;
    pair_model(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    drain();

    // Overflow: six pairs with downstream stalled, the last two are dropped.
    ready_in = 1'b0;
    for (int p = 0; p < 6; p++) begin
      send_pair(p[0], p[1], (p < FIFO_DEPTH) ? 1'b1 : 1'b0, 1'b0);
    end
    @(negedge clk);
    check("full_ready_out", 32'(ready_out), 32'd0);
    check("full_valid_out", 32'(valid_out), 32'd1);
    check("full_head_i_stable", 32'(i_out), 32'(sb[0].i));
    check("full_head_q_stable", 32'(q_out), 32'(sb[0].q));
`ifdef WIMAX_QPSK_OVF_STATUS_EN
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_fifo_level", 32'(fifo_level), 32'd4);
`endif

    // Full FIFO: push and pop in the same cycle the Q bit arrives.
    @(posedge clk); #1;
    valid_in = 1'b1;
    data_in  = 1'b1;
    @(posedge clk); #1;
    data_in  = 1'b1;
    ready_in = 1'b1;
    pair_model(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    check("pushpop_ready_out", 32'(ready_out), 32'd0);
    check("pushpop_valid_out", 32'(valid_out), 32'd1);
`ifdef WIMAX_QPSK_OVF_STATUS_EN
    check("pushpop_fifo_level", 32'(fifo_level), 32'd4);
`endif

    // Drain, then cross the block boundary to show last stays aligned after the drops.
    @(posedge clk); #1;
    ready_in = 1'b1;
    drain();
    for (int p = 0; p < SYMS + 2; p++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      send_pair(a, b, 1'b1, 1'b0);
    end
    drain();
`ifdef WIMAX_QPSK_OVF_STATUS_EN
    check("overflow_sticky", 32'(overflow), 32'd1);
`endif

    // Reset mid-block after the I bit of symbol 10 with symbols still queued.
    do_reset();
    ready_in = 1'b1;
    for (int p = 0; p < 8; p++) send_pair(p[0], p[2], 1'b1, 1'b0);
    @(posedge clk); #1;
    ready_in = 1'b0;
    send_pair(1'b0, 1'b1, 1'b1, 1'b0);
    send_pair(1'b1, 1'b0, 1'b1, 1'b0);
    valid_in = 1'b1;
    data_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    do_reset();
    ready_in = 1'b1;
    send_pair(1'b0, 1'b1, 1'b1, 1'b1);
    for (int p = 1; p < SYMS + 1; p++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      send_pair(a, b, 1'b1, 1'b0);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
